mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory-system port (BIOS/main SDRAM/scratchpad address interpreter) among
//  NUM_REQ requesters: req 0 = CPU instruction fetch, 1 = CPU data, 2 = DMA.
//  Sits between the requesters and the address interpreter; all sides use a 4-phase ren/wen/ack handshake.
//  Adds round-robin or fixed-priority arbitration and a watchdog so a lost downstream ack cannot hang a requester.
// PARAMETERS
//  NUM_REQ     3    number of requesters (2..8)
//  RR_EN       1    1 = round-robin, 0 = fixed priority (index 0 highest)
//  TIMEOUT     255  cycles in GRANT without m_ack before the transfer aborts with error
// PORTS
//  clk         in   1            clock
//  rst         in   1            reset, asynchronous, active-high
//  r_ren       in   NUM_REQ      per-requester read request, level, held until r_ack
//  r_wen       in   NUM_REQ      per-requester write request, level, held until r_ack
//  r_addr      in   32*NUM_REQ   per-requester byte address, slice i = [32*i+:32], stable while requesting
//  r_wdata     in   32*NUM_REQ   per-requester write data, slice i = [32*i+:32]
//  r_ack       out  NUM_REQ      per-requester ack, held until that requester drops ren/wen
//  r_err       out  NUM_REQ      per-requester error (timeout), valid while r_ack is high
//  r_rdata     out  32           read data, broadcast, valid while any r_ack is high
//  m_ren       out  1            to memory port: read request
//  m_wen       out  1            to memory port: write request
//  m_addr      out  32           to memory port: address of the granted requester
//  m_wdata     out  32           to memory port: write data of the granted requester
//  m_ack       in   1            from memory port: ack, held until m_ren/m_wen fall
//  m_rdata     in   32           from memory port: read data, valid when m_ack = 1
//  grant_id    out  3            index of the current or last granted requester (debug)
//  arb_state   out  4            one-hot FSM state (debug)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; timeout count 0. Reset mid-transfer aborts silently
//   with no ack to any requester. Upstream requesters are also reset.
//  All outputs are registered. m_addr and m_wdata are latched at grant and held until the next grant.
//  req[i] = r_ren[i] | r_wen[i]. If both are high, the transfer is a read (m_wen = 0).
//  FSM, one-hot: IDLE=0001, GRANT=0010, RESP=0100, DRAIN=1000.
//   IDLE:  if any req and m_ack == 0, select winner g, latch addr/wdata/type, set grant_id = g.
//          Next cycle is GRANT with m_ren/m_wen = 1 (request-to-m_ren latency is 1 clk).
//          If m_ack is still high from a prior transfer, stay in IDLE.
//   GRANT: hold m_ren/m_wen; count++.
//          On m_ack = 1: latch r_rdata = m_rdata (writes: 0), m_ren = m_wen = 0.
//          If req[g] is still high, go to RESP with r_ack[g] = 1; else go to DRAIN with no ack (dropout).
//          On count == TIMEOUT with no m_ack: m_ren = m_wen = 0, r_rdata = 0.
//          If req[g] is high, go to RESP with r_ack[g] = 1 and r_err[g] = 1; else go to DRAIN.
//          m_ack and timeout in the same cycle: m_ack wins, no error.
//   RESP:  hold r_ack[g] (and r_err[g]) until req[g] = 0, then clear them and go to DRAIN.
//   DRAIN: wait for m_ack = 0, then go to IDLE and clear count.
//          If RR_EN: rr pointer = (g+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
//  Round-robin: the winner is the first asserted req found scanning from the rr pointer upward with wrap.
//   Fixed priority: the winner is the lowest asserted index.
//  At most one r_ack bit is high at any time. m_ren and m_wen are never both high.
//   r_ack is never high together with m_ren/m_wen.
//  A requester that drops its request before ack gets no ack; the downstream transfer still completes.
//  Minimum back-to-back period: IDLE, GRANT (>=1), RESP (>=1), DRAIN (>=1) = 4 clks per transfer.
// TESTING
//  1. r_ren[1]=1, r_addr[1]=0x8000_0100; model acks after 3 clk with 0xDEAD_BEEF
//     -> m_ren 1 clk later with m_addr 0x8000_0100; r_ack[1]=1, r_rdata=0xDEAD_BEEF, r_err=0.
//  2. All 3 requesters hold reads continuously, RR_EN=1 -> grant order 0,1,2,0,1,2.
//     With RR_EN=0 -> only req 0 is served while it keeps re-requesting.
//  3. r_wen[2]=1, addr 0x1F80_0010, wdata 0x1234_5678 -> m_wen=1, m_wdata=0x1234_5678, m_ren=0.
//     Then r_ack[2]; m_wen drops on m_ack.
//  4. Model never acks, TIMEOUT=255 -> m_ren drops after 255 GRANT clks; r_ack=1, r_err=1, r_rdata=0.
//     The next request is served normally.
//  5. Requester 0 drops r_ren while in GRANT -> no r_ack[0]; the arbiter drains m_ack and then serves req 1.
//  6. rst asserted in GRANT -> m_ren, r_ack and grant_id are 0 immediately (async); state IDLE, rr pointer 0.
//     r_ren[0] and r_wen[0] both high -> a read is issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single memory-system port (BIOS / main SDRAM / scratchpad address
// interpreter) among NUM_REQ requesters: 0 = CPU instruction fetch,
// 1 = CPU data, 2 = DMA. Arbitration is round-robin (RR_EN = 1) or fixed
// priority with index 0 highest (RR_EN = 0). A watchdog aborts a transfer
// whose downstream ack never arrives, so no requester can hang.
//
// Handshake (every side, 4-phase level protocol):
//   the initiator raises ren or wen and holds it together with addr/wdata;
//   the target raises ack once the data is done and holds it; the initiator
//   then drops ren/wen; the target drops ack; only then may a new request
//   start. Both ren and wen high at once is treated as a read.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   r_ren, r_wen        per-requester read / write request (level)
//   r_addr, r_wdata     per-requester address / write data, slice i = [32*i +: 32]
//   r_ack, r_err        per-requester ack, and timeout error valid with ack
//   r_rdata             read data broadcast to all requesters
//   m_ren, m_wen        request towards the memory port
//   m_addr, m_wdata     address / write data of the granted requester
//   m_ack, m_rdata      ack and read data from the memory port
//   grant_id            current or last granted requester (debug)
//   arb_state           one-hot FSM state (debug)

module mem_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      r_ren,
    input  logic [NUM_REQ-1:0]      r_wen,
    input  logic [32*NUM_REQ-1:0]   r_addr,
    input  logic [32*NUM_REQ-1:0]   r_wdata,
    output logic [NUM_REQ-1:0]      r_ack,
    output logic [NUM_REQ-1:0]      r_err,
    output logic [31:0]             r_rdata,
    output logic                    m_ren,
    output logic                    m_wen,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    input  logic                    m_ack,
    input  logic [31:0]             m_rdata,
    output logic [2:0]              grant_id,
    output logic [3:0]              arb_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        GRANT = 4'b0010,
        RESP  = 4'b0100,
        DRAIN = 4'b1000
    } state_t;

    state_t              state;
    logic [2:0]          rr_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_inc;

    logic [NUM_REQ-1:0]  req;
    logic                any_req;
    logic [NUM_REQ-1:0]  g_mask;
    logic                req_g;

    logic [2:0]          win;
    logic                win_found;
    int                  scan_idx;

    assign req       = r_ren | r_wen;
    assign any_req   = |req;
    assign g_mask    = NUM_REQ'(1) << grant_id;
    assign req_g     = |(req & g_mask);
    assign count_inc = count + 1'b1;
    assign arb_state = state;

    // Winner selection. Round-robin scans upward from rr_ptr with wrap;
    // fixed priority scans from index 0. The first asserted request wins.
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (RR_EN != 0) begin
                scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            end else begin
                scan_idx = k;
            end
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win       = 3'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= 3'd0;
            count    <= '0;
            grant_id <= 3'd0;
            m_ren    <= 1'b0;
            m_wen    <= 1'b0;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
            r_ack    <= '0;
            r_err    <= '0;
            r_rdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A still-high m_ack belongs to the previous transfer;
                    // starting now would confuse it with the new one.
                    if (any_req && !m_ack) begin
                        grant_id <= win;
                        m_addr   <= r_addr[32*int'(win) +: 32];
                        m_wdata  <= r_wdata[32*int'(win) +: 32];
                        // req[win] is known high, so ren low implies a write.
                        m_ren    <= r_ren[win];
                        m_wen    <= ~r_ren[win];
                        count    <= '0;
                        state    <= GRANT;
                    end
                end

                GRANT: begin
                    count <= count_inc;
                    if (m_ack) begin
                        // An ack arriving on the timeout cycle still counts
                        // as a good transfer, so it is tested first.
                        m_ren   <= 1'b0;
                        m_wen   <= 1'b0;
                        r_rdata <= m_ren ? m_rdata : 32'd0;
                        if (req_g) begin
                            r_ack <= g_mask;
                            r_err <= '0;
                            state <= RESP;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (count_inc == CW'(TIMEOUT)) begin
                        m_ren   <= 1'b0;
                        m_wen   <= 1'b0;
                        r_rdata <= 32'd0;
                        if (req_g) begin
                            r_ack <= g_mask;
                            r_err <= g_mask;
                            state <= RESP;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end

                RESP: begin
                    if (!req_g) begin
                        r_ack <= '0;
                        r_err <= '0;
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Wait for the memory side to complete its handshake
                    // before the port is offered to anyone else.
                    if (!m_ack) begin
                        count <= '0;
                        state <= IDLE;
                        if (RR_EN != 0) begin
                            if (grant_id == 3'(NUM_REQ - 1)) begin
                                rr_ptr <= 3'd0;
                            end else begin
                                rr_ptr <= grant_id + 3'd1;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance (TIMEOUT 255) with a
// programmable memory responder, and a fixed-priority instance with an
// always-acking responder.

module tb_mem_port_arbiter;

    localparam int N = 3;
    localparam int W = 68;  // {grant_id, is_write, addr, wdata}
    localparam logic [31:0] FN_KEY = 32'hC3C3_3C3C;

    logic clk;
    logic rst;

    // ---------------- round-robin instance ----------------
    logic [N-1:0]    r_ren, r_wen;
    logic [32*N-1:0] r_addr, r_wdata;
    logic [N-1:0]    r_ack, r_err;
    logic [31:0]     r_rdata;
    logic            m_ren, m_wen;
    logic [31:0]     m_addr, m_wdata;
    logic            m_ack;
    logic [31:0]     m_rdata;
    logic [2:0]      grant_id;
    logic [3:0]      arb_state;

    // ---------------- fixed-priority instance ----------------
    logic [N-1:0]    b_r_ren, b_r_wen;
    logic [32*N-1:0] b_r_addr, b_r_wdata;
    logic [N-1:0]    b_r_ack, b_r_err;
    logic [31:0]     b_r_rdata;
    logic            b_m_ren, b_m_wen;
    logic [31:0]     b_m_addr, b_m_wdata;
    logic            b_m_ack;
    logic [31:0]     b_m_rdata;
    logic [2:0]      b_grant_id;
    logic [3:0]      b_arb_state;

    mem_port_arbiter #(.NUM_REQ(N), .RR_EN(1), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .r_ren(r_ren), .r_wen(r_wen), .r_addr(r_addr), .r_wdata(r_wdata),
        .r_ack(r_ack), .r_err(r_err), .r_rdata(r_rdata),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .grant_id(grant_id), .arb_state(arb_state)
    );

    mem_port_arbiter #(.NUM_REQ(N), .RR_EN(0), .TIMEOUT(15)) dut_fp (
        .clk(clk), .rst(rst),
        .r_ren(b_r_ren), .r_wen(b_r_wen), .r_addr(b_r_addr), .r_wdata(b_r_wdata),
        .r_ack(b_r_ack), .r_err(b_r_err), .r_rdata(b_r_rdata),
        .m_ren(b_m_ren), .m_wen(b_m_wen), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_ack(b_m_ack), .m_rdata(b_m_rdata),
        .grant_id(b_grant_id), .arb_state(b_arb_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;
    logic [W-1:0] exp_q[$];
    int exp_len;            // expected m_ren/m_wen high cycles of next transfer, 0 = unchecked

    // memory responder controls
    int          mem_lat;
    logic        mem_never;
    logic        mem_use_fn;
    logic [31:0] mem_val;

    typedef struct {
        int          idx;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        never;
        logic [31:0] mval;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_len;
    } vec_t;

    vec_t vecs[8];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_sb(input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL sb_grant: got id=%0d wr=%0b addr=0x%08h wdata=0x%08h expected id=%0d wr=%0b addr=0x%08h wdata=0x%08h",
                     got[67:65], got[64], got[63:32], got[31:0],
                     exp[67:65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- memory responder (round-robin instance) ----------------
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        m_ack    = 1'b0;
        m_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (m_ack) begin
                if (!m_ren && !m_wen) begin
                    m_ack   = 1'b0;
                    m_rdata = 32'd0;
                end
            end else if (m_ren || m_wen) begin
                wait_cnt++;
                if (!mem_never && wait_cnt >= mem_lat) begin
                    m_ack    = 1'b1;
                    m_rdata  = m_ren ? (mem_use_fn ? (m_addr ^ FN_KEY) : mem_val) : 32'd0;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- memory responder (fixed-priority instance) ----------------
    initial begin
        b_m_ack   = 1'b0;
        b_m_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (b_m_ack) begin
                if (!b_m_ren && !b_m_wen) b_m_ack = 1'b0;
            end else if (b_m_ren || b_m_wen) begin
                b_m_ack   = 1'b1;
                b_m_rdata = b_m_addr;
            end
        end
    end

    // ---------------- scoreboard monitor and invariants ----------------
    task automatic monitor_loop();
        logic prev;
        logic cur;
        int   len;
        prev = 1'b0;
        len  = 0;
        forever begin
            @(negedge clk);
            cur = m_ren | m_wen;
            if (!rst) begin
                if ($countones(r_ack) > 1) check32("inv_single_ack", 32'($countones(r_ack)), 32'd1);
                if (m_ren && m_wen) check32("inv_ren_wen_excl", {30'd0, m_ren, m_wen}, 32'd2);
                if ((|r_ack) && cur) check32("inv_ack_vs_mreq", {31'd0, cur}, 32'd0);
                if ((r_err & ~r_ack) != '0) check32("inv_err_without_ack", 32'(r_err), 32'(r_err & r_ack));
            end
            if (cur && !prev) begin
                if (exp_q.size() == 0) begin
                    fail_now("sb_unexpected_grant");
                end else begin
                    check_sb({grant_id, m_wen, m_addr, m_wdata}, exp_q.pop_front());
                end
            end
            if (cur) len++;
            if (!cur && prev) begin
                if (exp_len != 0) check32("grant_len", 32'(len), 32'(exp_len));
                exp_len = 0;
                len = 0;
            end
            if (!cur) len = 0;
            prev = cur;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (arb_state != 4'b0001 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (arb_state != 4'b0001) fail_now("wait_idle");
    endtask

    // One complete single-requester transfer driven from a table entry.
    task automatic run_vec(input vec_t v, input int n);
        int idx;
        int waited;
        string tag;
        idx = v.idx;
        tag = $sformatf("vec%0d", n);
        wait_idle();
        mem_lat    = v.lat;
        mem_never  = v.never;
        mem_val    = v.mval;
        mem_use_fn = 1'b0;
        exp_len    = v.exp_len;
        exp_q.push_back({3'(idx), v.wr & ~v.rd, v.addr, v.wdata});
        r_addr[32*idx +: 32]  = v.addr;
        r_wdata[32*idx +: 32] = v.wdata;
        r_ren[idx] = v.rd;
        r_wen[idx] = v.wr;
        @(negedge clk);
        check32({tag, "_mreq_latency"}, {31'd0, m_ren | m_wen}, 32'd1);
        waited = 0;
        while (!r_ack[idx] && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!r_ack[idx]) begin
            fail_now({tag, "_ack"});
        end else begin
            check32({tag, "_err"},   {31'd0, r_err[idx]}, {31'd0, v.exp_err});
            check32({tag, "_rdata"}, r_rdata, v.exp_rdata);
        end
        r_ren[idx] = 1'b0;
        r_wen[idx] = 1'b0;
        waited = 0;
        while (r_ack[idx] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (r_ack[idx]) fail_now({tag, "_ack_release"});
    endtask

    // ---------------- global watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a_addr [N];
        int          served [N];
        int          budget;
        int          ack0_seen;
        int          seq_exp [6];
        int          pos;
        logic        done;

        checks = 0;
        errors = 0;
        exp_len = 0;
        mem_lat = 1; mem_never = 1'b0; mem_use_fn = 1'b0; mem_val = 32'd0;
        r_ren = '0; r_wen = '0; r_addr = '0; r_wdata = '0;
        b_r_ren = '0; b_r_wen = '0; b_r_addr = '0; b_r_wdata = '0;

        //            idx rd    wr    addr          wdata         lat never mval          err   rdata         len
        vecs[0] = '{1, 1'b1, 1'b0, 32'h8000_0100, 32'h0000_0000, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 0};
        vecs[1] = '{2, 1'b0, 1'b1, 32'h1F80_0010, 32'h1234_5678, 2, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 0};
        vecs[2] = '{0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 0};
        vecs[3] = '{0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 1, 1'b1, 32'h7777_7777, 1'b1, 32'h0000_0000, 255};
        vecs[4] = '{0, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, 1, 1'b0, 32'h1111_2222, 1'b0, 32'h1111_2222, 0};
        vecs[5] = '{1, 1'b1, 1'b1, 32'h8000_0200, 32'hCAFE_0001, 2, 1'b0, 32'h3333_4444, 1'b0, 32'h3333_4444, 0};
        vecs[6] = '{2, 1'b0, 1'b1, 32'h1F80_0020, 32'h9ABC_DEF0, 1, 1'b0, 32'h5555_5555, 1'b0, 32'h0000_0000, 0};
        vecs[7] = '{1, 1'b1, 1'b0, 32'h8000_0300, 32'h0000_0000, 5, 1'b0, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 0};

        fork
            monitor_loop();
        join_none

        // ---- reset values ----
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check32("rst_m_ren",     {31'd0, m_ren}, 32'd0);
        check32("rst_m_wen",     {31'd0, m_wen}, 32'd0);
        check32("rst_r_ack",     32'(r_ack), 32'd0);
        check32("rst_r_err",     32'(r_err), 32'd0);
        check32("rst_r_rdata",   r_rdata, 32'd0);
        check32("rst_m_addr",    m_addr, 32'd0);
        check32("rst_grant_id",  32'(grant_id), 32'd0);
        check32("rst_arb_state", 32'(arb_state), 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // ---- single-requester table: read, write, timeout, recovery, ren+wen ----
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // ---- asynchronous reset in the middle of a granted transfer ----
        wait_idle();
        mem_never = 1'b1;
        r_addr[64 +: 32] = 32'h0000_2000;
        r_wdata[64 +: 32] = 32'd0;
        exp_q.push_back({3'd2, 1'b0, 32'h0000_2000, 32'd0});
        r_ren[2] = 1'b1;
        repeat (3) @(negedge clk);
        check32("pre_rst_state", 32'(arb_state), 32'h2);
        check32("pre_rst_m_ren", {31'd0, m_ren}, 32'd1);
        rst = 1'b1;
        r_ren = '0;
        #1;
        check32("async_rst_m_ren",    {31'd0, m_ren}, 32'd0);
        check32("async_rst_r_ack",    32'(r_ack), 32'd0);
        check32("async_rst_grant_id", 32'(grant_id), 32'd0);
        check32("async_rst_state",    32'(arb_state), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        mem_never = 1'b0;
        @(negedge clk);

        // ---- round robin with all requesters re-requesting: 0,1,2,0,1,2 ----
        mem_use_fn = 1'b1;
        mem_lat    = 2;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = 32'h0000_1000 + 32'(16 * i);
            r_addr[32*i +: 32]  = a_addr[i];
            r_wdata[32*i +: 32] = 32'd0;
            served[i] = 0;
        end
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < N; i++) exp_q.push_back({3'(i), 1'b0, a_addr[i], 32'd0});
        end
        r_ren = 3'b111;
        done = 1'b0;
        budget = 0;
        while (!done && budget < 3000) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < N; i++) begin
                if (r_ack[i] && r_ren[i]) begin
                    check32($sformatf("rr_rdata_%0d", i), r_rdata, a_addr[i] ^ FN_KEY);
                    served[i]++;
                    r_ren[i] = 1'b0;
                end else if (!r_ack[i] && !r_ren[i] && served[i] < 2) begin
                    r_ren[i] = 1'b1;
                end
            end
            done = (served[0] == 2) && (served[1] == 2) && (served[2] == 2) && (r_ack == '0);
        end
        if (!done) fail_now("rr_sequence");
        r_ren = '0;
        mem_use_fn = 1'b0;

        // ---- requester 0 drops out during GRANT, requester 1 then served ----
        wait_idle();
        mem_lat = 4;
        mem_val = 32'h600D_0001;
        r_addr[0 +: 32]  = 32'h0000_3000;
        r_addr[32 +: 32] = 32'h0000_3100;
        exp_q.push_back({3'd0, 1'b0, 32'h0000_3000, 32'd0});
        exp_q.push_back({3'd1, 1'b0, 32'h0000_3100, 32'd0});
        r_ren[0] = 1'b1;
        r_ren[1] = 1'b1;
        @(negedge clk);
        check32("drop_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        r_ren[0] = 1'b0;
        ack0_seen = 0;
        budget = 0;
        while (!r_ack[1] && budget < 200) begin
            @(negedge clk);
            budget++;
            if (r_ack[0]) ack0_seen++;
        end
        check32("drop_no_ack0", 32'(ack0_seen), 32'd0);
        if (!r_ack[1]) begin
            fail_now("drop_ack1");
        end else begin
            check32("drop_rdata1", r_rdata, 32'h600D_0001);
        end
        r_ren[1] = 1'b0;
        repeat (2) @(negedge clk);
        check32("drop_ack1_release", 32'(r_ack), 32'd0);

        // ---- fixed priority: 0 keeps winning while it re-requests ----
        for (int i = 0; i < N; i++) b_r_addr[32*i +: 32] = 32'h0000_0B00 + 32'(i);
        seq_exp = '{0, 0, 0, 0, 1, 2};
        pos = 0;
        served[0] = 0;
        b_r_ren = 3'b111;
        budget = 0;
        while (pos < 6 && budget < 500) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < N; i++) begin
                if (b_r_ack[i] && b_r_ren[i]) begin
                    check32($sformatf("fp_order_%0d", pos), 32'(i), 32'(seq_exp[pos]));
                    check32($sformatf("fp_rdata_%0d", pos), b_r_rdata, 32'h0000_0B00 + 32'(i));
                    pos++;
                    if (i == 0) served[0]++;
                    b_r_ren[i] = 1'b0;
                end else if (i == 0 && !b_r_ack[0] && !b_r_ren[0] && served[0] < 4) begin
                    b_r_ren[0] = 1'b1;
                end
            end
        end
        if (pos < 6) fail_now("fp_sequence");
        b_r_ren = '0;

        repeat (4) @(negedge clk);
        check32("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
